snd_cmd_queue: RTL and testbench

//  Parametrised sound-command mailbox from main CPU to audio CPU: successor to the single
//  snd_latch + stretched-IRQ logic. Main CPU writes commands; the audio CPU is interrupted
//  and pops them. MODE selects legacy single-latch (overwrite) or queued (FIFO) operation.

---
 rtl/snd_cmd_queue.sv | 199 +++++++++++++++++++
 tb/tb_snd_cmd_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_cmd_queue.sv
// Sound-command mailbox from main CPU to audio CPU.
// MODE=0 behaves as a single overwrite latch; MODE=1 is a DEPTH-entry FIFO.
// Every accepted write, and in FIFO mode every pop that leaves entries behind,
// raises a paced active-low IRQ pulse towards the audio CPU.
module snd_cmd_queue #(
   parameter int unsigned DW       = 8,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned IRQ_HOLD = 3,
   parameter int unsigned MODE     = 1
) (
   input  logic                     clk_sys,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [DW-1:0]            wr_data,
   output logic                     full,
   input  logic                     rd_en,
   output logic [DW-1:0]            rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     ovf_clr,
   input  logic                     irq_ce,
   input  logic                     irq_ack,
   output logic                     irq_n
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned HW = $clog2(IRQ_HOLD + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [HW-1:0] HOLD_C  = HW'(IRQ_HOLD);

   typedef enum logic [1:0] {
      IRQ_IDLE,
      IRQ_PULSE,
      IRQ_GAP
   } irq_state_e;

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;
   logic          ovf_q, ovf_d;
   logic [DW-1:0] rd_data_q;

   logic          wr_acc;
   logic          rd_acc;
   logic          req;

   irq_state_e    state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          irq_n_q, irq_n_d;
   logic          pend_q, pend_d;
   logic          pend_clr;

   // Accept/reject decisions and next pointer/flag values for both modes.
   // In latch mode the pointers never move, so mem[0] serves as the latch and
   // count doubles as the "fresh" bit.
   always_comb begin
      wr_acc  = 1'b0;
      rd_acc  = 1'b0;
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      full_d  = 1'b0;
      ovf_d   = 1'b0;
      req     = 1'b0;
      if (MODE == 0) begin
         wr_acc = wr_en;
         rd_acc = rd_en;
         if (wr_en) begin
            count_d = CW'(1);
         end else if (rd_en) begin
            count_d = '0;
         end
         req = wr_en;
      end else begin
         // A full queue still accepts a write when a pop frees the slot same edge.
         wr_acc  = wr_en & (~full_q | rd_en);
         rd_acc  = rd_en & ~empty_q;
         wp_d    = wr_acc ? wp_q + 1'b1 : wp_q;
         rp_d    = rd_acc ? rp_q + 1'b1 : rp_q;
         count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
         full_d  = (count_d == DEPTH_C);
         if (wr_en & full_q & ~rd_en) begin
            ovf_d = 1'b1;
         end else if (ovf_clr) begin
            ovf_d = 1'b0;
         end else begin
            ovf_d = ovf_q;
         end
         req = wr_acc | (rd_acc & (count_d != '0));
      end
      empty_d = (count_d == '0);
   end

   // Command storage; contents are don't-care after reset.
   always_ff @(posedge clk_sys) begin
      if (wr_acc) begin
         mem[wp_q] <= wr_data;
      end
   end

   // Pointers, flags and the registered read port.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wp_q      <= '0;
         rp_q      <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ovf_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ovf_q   <= ovf_d;
         if (rd_acc) begin
            rd_data_q <= mem[rp_q];
         end
      end
   end

   // IRQ pacing: pulse low for IRQ_HOLD ticks, then one guaranteed high tick.
   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      irq_n_d  = irq_n_q;
      pend_clr = 1'b0;
      case (state_q)
         IRQ_IDLE: begin
            if (irq_ce && pend_q) begin
               state_d  = IRQ_PULSE;
               irq_n_d  = 1'b0;
               hold_d   = HOLD_C;
               pend_clr = 1'b1;
            end
         end
         IRQ_PULSE: begin
            if (irq_ack) begin
               state_d = IRQ_GAP;
               irq_n_d = 1'b1;
            end else if (irq_ce) begin
               hold_d = hold_q - 1'b1;
               if (hold_q == HW'(1)) begin
                  state_d = IRQ_GAP;
                  irq_n_d = 1'b1;
               end
            end
         end
         IRQ_GAP: begin
            if (irq_ce) begin
               state_d = IRQ_IDLE;
            end
         end
         default: begin
            state_d = IRQ_IDLE;
            irq_n_d = 1'b1;
         end
      endcase
      // A new request wins over the clear issued when a pulse starts.
      if (req) begin
         pend_d = 1'b1;
      end else if (pend_clr) begin
         pend_d = 1'b0;
      end else begin
         pend_d = pend_q;
      end
   end

   // IRQ state register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IRQ_IDLE;
         hold_q  <= '0;
         irq_n_q <= 1'b1;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         irq_n_q <= irq_n_d;
         pend_q  <= pend_d;
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = ovf_q;
   assign rd_data  = rd_data_q;
   assign irq_n    = irq_n_q;

endmodule

// File: tb/tb_snd_cmd_queue.sv
// Directed bench for snd_cmd_queue: one FIFO-mode and one latch-mode instance
// share clock, reset and irq_ce; expected values are hand-computed constants.
module tb_snd_cmd_queue;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       irq_ce;

   // FIFO-mode instance signals
   logic       q_wr_en, q_rd_en, q_ovf_clr, q_irq_ack;
   logic [7:0] q_wr_data, q_rd_data;
   logic       q_full, q_empty, q_overflow, q_irq_n;
   logic [2:0] q_count;

   // Latch-mode instance signals
   logic       l_wr_en, l_rd_en, l_ovf_clr, l_irq_ack;
   logic [7:0] l_wr_data, l_rd_data;
   logic       l_full, l_empty, l_overflow, l_irq_n;
   logic [2:0] l_count;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   snd_cmd_queue #(.DW(8), .DEPTH(4), .IRQ_HOLD(3), .MODE(1)) u_q (
      .clk_sys(clk), .reset_n(reset_n),
      .wr_en(q_wr_en), .wr_data(q_wr_data), .full(q_full),
      .rd_en(q_rd_en), .rd_data(q_rd_data), .empty(q_empty),
      .count(q_count), .overflow(q_overflow), .ovf_clr(q_ovf_clr),
      .irq_ce(irq_ce), .irq_ack(q_irq_ack), .irq_n(q_irq_n)
   );

   snd_cmd_queue #(.DW(8), .DEPTH(4), .IRQ_HOLD(3), .MODE(0)) u_l (
      .clk_sys(clk), .reset_n(reset_n),
      .wr_en(l_wr_en), .wr_data(l_wr_data), .full(l_full),
      .rd_en(l_rd_en), .rd_data(l_rd_data), .empty(l_empty),
      .count(l_count), .overflow(l_overflow), .ovf_clr(l_ovf_clr),
      .irq_ce(irq_ce), .irq_ack(l_irq_ack), .irq_n(l_irq_n)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Three idle cycles then one irq_ce cycle; returns just after the irq_ce edge.
   task automatic ce_tick();
      irq_ce = 1'b0;
      repeat (3) step();
      irq_ce = 1'b1;
      step();
      irq_ce = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic q_write(input logic [7:0] d);
      q_wr_en = 1'b1;
      q_wr_data = d;
      step();
      q_wr_en = 1'b0;
   endtask

   task automatic q_pop();
      q_rd_en = 1'b1;
      step();
      q_rd_en = 1'b0;
   endtask

   task automatic l_write(input logic [7:0] d);
      l_wr_en = 1'b1;
      l_wr_data = d;
      step();
      l_wr_en = 1'b0;
   endtask

   task automatic l_pop();
      l_rd_en = 1'b1;
      step();
      l_rd_en = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      irq_ce = 1'b0;
      q_wr_en = 1'b0; q_rd_en = 1'b0; q_ovf_clr = 1'b0; q_irq_ack = 1'b0; q_wr_data = '0;
      l_wr_en = 1'b0; l_rd_en = 1'b0; l_ovf_clr = 1'b0; l_irq_ack = 1'b0; l_wr_data = '0;

      // Reset state
      step();
      step();
      check_eq("rst_count", q_count, 0);
      check_eq("rst_empty", q_empty, 1);
      check_eq("rst_full", q_full, 0);
      check_eq("rst_ovf", q_overflow, 0);
      check_eq("rst_rdata", q_rd_data, 0);
      check_eq("rst_irq_n", q_irq_n, 1);
      check_eq("rst_l_empty", l_empty, 1);
      reset_n = 1'b1;
      step();

      // 1: basic FIFO ordering
      q_write(8'h11);
      q_write(8'h22);
      q_write(8'h33);
      check_eq("t1_count3", q_count, 3);
      check_eq("t1_empty0", q_empty, 0);
      q_pop();
      check_eq("t1_rd11", q_rd_data, 8'h11);
      check_eq("t1_count2", q_count, 2);
      q_pop();
      check_eq("t1_rd22", q_rd_data, 8'h22);
      q_pop();
      check_eq("t1_rd33", q_rd_data, 8'h33);
      check_eq("t1_count0", q_count, 0);
      check_eq("t1_empty1", q_empty, 1);
      q_pop();
      check_eq("t1_rd_hold", q_rd_data, 8'h33);
      check_eq("t1_count_stay0", q_count, 0);

      // 2: full and overflow
      do_reset();
      for (int i = 1; i <= 4; i++) q_write(8'(i));
      check_eq("t2_full", q_full, 1);
      check_eq("t2_count4", q_count, 4);
      check_eq("t2_ovf0", q_overflow, 0);
      q_write(8'h05);
      check_eq("t2_ovf1", q_overflow, 1);
      check_eq("t2_count_still4", q_count, 4);
      for (int i = 1; i <= 4; i++) begin
         q_pop();
         check_eq("t2_pop", q_rd_data, 8'(i));
      end
      check_eq("t2_empty", q_empty, 1);
      q_ovf_clr = 1'b1;
      step();
      q_ovf_clr = 1'b0;
      check_eq("t2_ovf_clr", q_overflow, 0);
      for (int i = 0; i < 4; i++) q_write(8'hE0 + 8'(i));
      q_ovf_clr = 1'b1;
      q_write(8'hEE);
      q_ovf_clr = 1'b0;
      check_eq("t2_ovf_set_wins", q_overflow, 1);

      // 3: full with simultaneous write and pop
      do_reset();
      for (int i = 1; i <= 4; i++) q_write(8'(i));
      q_wr_en = 1'b1;
      q_wr_data = 8'hAA;
      q_rd_en = 1'b1;
      step();
      q_wr_en = 1'b0;
      q_rd_en = 1'b0;
      check_eq("t3_rd_oldest", q_rd_data, 8'h01);
      check_eq("t3_count4", q_count, 4);
      check_eq("t3_full", q_full, 1);
      check_eq("t3_ovf0", q_overflow, 0);
      q_pop();
      check_eq("t3_rd02", q_rd_data, 8'h02);
      q_pop();
      q_pop();
      check_eq("t3_rd04", q_rd_data, 8'h04);
      q_pop();
      check_eq("t3_rdAA", q_rd_data, 8'hAA);
      check_eq("t3_empty", q_empty, 1);

      // 4: IRQ pulse timing
      do_reset();
      q_write(8'h77);
      check_eq("t4_pre_irq", q_irq_n, 1);
      ce_tick();
      check_eq("t4_low_t0", q_irq_n, 0);
      ce_tick();
      check_eq("t4_low_t1", q_irq_n, 0);
      ce_tick();
      check_eq("t4_low_t2", q_irq_n, 0);
      ce_tick();
      check_eq("t4_high_t3", q_irq_n, 1);
      ce_tick();
      check_eq("t4_gap_t4", q_irq_n, 1);
      ce_tick();
      check_eq("t4_no_second", q_irq_n, 1);
      q_write(8'h88);
      ce_tick();
      check_eq("t4b_low_t0", q_irq_n, 0);
      ce_tick();
      q_write(8'h99);
      ce_tick();
      check_eq("t4b_low_t2", q_irq_n, 0);
      ce_tick();
      check_eq("t4b_no_restart", q_irq_n, 1);
      ce_tick();
      check_eq("t4b_gap", q_irq_n, 1);
      ce_tick();
      check_eq("t4b_second_pulse", q_irq_n, 0);
      ce_tick();
      ce_tick();
      check_eq("t4b_second_low", q_irq_n, 0);
      ce_tick();
      check_eq("t4b_second_end", q_irq_n, 1);

      // 5: latch mode
      do_reset();
      l_write(8'h5A);
      check_eq("t5_full0a", l_full, 0);
      ce_tick();
      check_eq("t5_p1_low", l_irq_n, 0);
      l_write(8'hA5);
      check_eq("t5_count1", l_count, 1);
      check_eq("t5_full0b", l_full, 0);
      ce_tick();
      ce_tick();
      ce_tick();
      check_eq("t5_p1_end", l_irq_n, 1);
      ce_tick();
      ce_tick();
      check_eq("t5_p2_low", l_irq_n, 0);
      l_irq_ack = 1'b1;
      step();
      l_irq_ack = 1'b0;
      check_eq("t5_ack_high", l_irq_n, 1);
      l_pop();
      check_eq("t5_rdA5", l_rd_data, 8'hA5);
      check_eq("t5_empty", l_empty, 1);
      check_eq("t5_count0", l_count, 0);
      l_write(8'h3C);
      l_wr_en = 1'b1;
      l_wr_data = 8'hC3;
      l_rd_en = 1'b1;
      step();
      l_wr_en = 1'b0;
      l_rd_en = 1'b0;
      check_eq("t5_wr_rd_old", l_rd_data, 8'h3C);
      check_eq("t5_fresh_kept", l_empty, 0);
      l_pop();
      check_eq("t5_rdC3", l_rd_data, 8'hC3);
      check_eq("t5_ovf0", l_overflow, 0);

      // 6: asynchronous reset mid-pulse
      do_reset();
      q_write(8'h10);
      q_write(8'h20);
      ce_tick();
      check_eq("t6_pulse", q_irq_n, 0);
      check_eq("t6_count2", q_count, 2);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("t6_async_irq", q_irq_n, 1);
      check_eq("t6_async_count", q_count, 0);
      check_eq("t6_async_empty", q_empty, 1);
      step();
      reset_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
